// File: rtl/cpu_pkg.sv
// Shared encodings for the PC sequencer: FSM states, exception causes and vectors.
package cpu_pkg;

    localparam int unsigned PC_W = 32;

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_EXT      = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    localparam logic [PC_W-1:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [PC_W-1:0] EXC_VEC_DEF   = 32'h0000_0080;

    // Word-aligned targets only; any set low bit is a fault.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: forced exception > jump > branch > sequential, with alignment checks.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(EXC_VEC_DEF)
) (
    input  logic [WIDTH-1:0] pc_cur_i,
    input  logic             timeout_i,
    input  logic             ext_i,
    input  logic             jump_i,
    input  logic [WIDTH-1:0] jump_target_i,
    input  logic             branch_i,
    input  logic [WIDTH-1:0] branch_target_i,
    output logic [WIDTH-1:0] pc_next_o,
    output logic             exc_take_o,
    output logic [1:0]       cause_o
);

    always_comb begin
        pc_next_o  = pc_cur_i + WIDTH'(4);
        exc_take_o = 1'b0;
        cause_o    = CAUSE_NONE;
        if (timeout_i || ext_i) begin
            pc_next_o  = EXC_VEC;
            exc_take_o = 1'b1;
            cause_o    = timeout_i ? CAUSE_TIMEOUT : CAUSE_EXT;
        end else if (jump_i) begin
            if (misaligned(jump_target_i[1:0])) begin
                pc_next_o  = EXC_VEC;
                exc_take_o = 1'b1;
                cause_o    = CAUSE_MISALIGN;
            end else begin
                pc_next_o = jump_target_i;
            end
        end else if (branch_i) begin
            if (misaligned(branch_target_i[1:0])) begin
                pc_next_o  = EXC_VEC;
                exc_take_o = 1'b1;
                cause_o    = CAUSE_MISALIGN;
            end else begin
                pc_next_o = branch_target_i;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle PC controller: INIT -> FETCH -> DECODE -> UPDATE, driving the PC register
// load enable and data input, and recording exception cause/EPC.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH         = 32,
    parameter logic [WIDTH-1:0] RESET_VEC     = WIDTH'(RESET_VEC_DEF),
    parameter logic [WIDTH-1:0] EXC_VEC       = WIDTH'(EXC_VEC_DEF),
    parameter int unsigned      FETCH_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_cur,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_next,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_load,
    input  logic             dec_done,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             ext_exc,
    output logic [WIDTH-1:0] epc,
    output logic [1:0]       exc_cause
);

    localparam int unsigned CNT_W = $clog2(FETCH_TIMEOUT + 1);

    logic [1:0]       state_q,    state_d;
    logic             pc_load_q,  pc_load_d;
    logic             imem_req_q, imem_req_d;
    logic             ir_load_q,  ir_load_d;
    logic [WIDTH-1:0] epc_q,      epc_d;
    logic [1:0]       cause_q,    cause_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             pend_q,     pend_d;
    logic             tmo_q,      tmo_d;

    logic [WIDTH-1:0] sel_pc;
    logic             sel_exc;
    logic [1:0]       sel_cause;

    pc_next_sel #(
        .WIDTH  (WIDTH),
        .EXC_VEC(EXC_VEC)
    ) u_sel (
        .pc_cur_i       (pc_cur),
        .timeout_i      (tmo_q),
        .ext_i          (pend_q | ext_exc),
        .jump_i         (jump),
        .jump_target_i  (jump_target),
        .branch_i       (branch_taken),
        .branch_target_i(branch_target),
        .pc_next_o      (sel_pc),
        .exc_take_o     (sel_exc),
        .cause_o        (sel_cause)
    );

    // Load cycles happen in INIT and UPDATE; the load enable is pre-registered one edge earlier.
    always_comb begin
        state_d    = state_q;
        pc_load_d  = 1'b0;
        imem_req_d = 1'b0;
        ir_load_d  = 1'b0;
        epc_d      = epc_q;
        cause_d    = cause_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        tmo_d      = tmo_q;
        case (state_q)
            ST_INIT: begin
                if (pc_load_q) begin
                    state_d    = ST_FETCH;
                    imem_req_d = 1'b1;
                end else begin
                    pc_load_d = 1'b1;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d   = ST_DECODE;
                    ir_load_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_W'(FETCH_TIMEOUT - 1)) begin
                    state_d   = ST_UPDATE;
                    tmo_d     = 1'b1;
                    cnt_d     = '0;
                    pc_load_d = !stall;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    imem_req_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (ext_exc) pend_d = 1'b1;
                if (dec_done) begin
                    state_d   = ST_UPDATE;
                    pc_load_d = !stall;
                end
            end
            ST_UPDATE: begin
                if (pc_load_q) begin
                    state_d    = ST_FETCH;
                    imem_req_d = 1'b1;
                    pend_d     = 1'b0;
                    tmo_d      = 1'b0;
                    if (sel_exc) begin
                        epc_d   = pc_cur;
                        cause_d = sel_cause;
                    end
                end else begin
                    if (ext_exc) pend_d = 1'b1;
                    pc_load_d = !stall;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            pc_load_q  <= 1'b0;
            imem_req_q <= 1'b0;
            ir_load_q  <= 1'b0;
            epc_q      <= '0;
            cause_q    <= CAUSE_NONE;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_load_q  <= pc_load_d;
            imem_req_q <= imem_req_d;
            ir_load_q  <= ir_load_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            tmo_q      <= tmo_d;
        end
    end

    assign pc_next   = (state_q == ST_UPDATE) ? sel_pc :
                       (state_q == ST_INIT)   ? RESET_VEC : pc_cur;
    assign pc_load   = pc_load_q;
    assign imem_req  = imem_req_q;
    assign ir_load   = ir_load_q;
    assign epc       = epc_q;
    assign exc_cause = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, reset corner cases, then random
// instructions checked against an instruction-level timing/priority model.
module tb_pc_sequencer;

    localparam logic [31:0] RST_V = 32'h0000_0000;
    localparam logic [31:0] EXC_V = 32'h0000_0080;
    localparam int          TMO   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        imem_req;
    logic        imem_ack;
    logic        ir_load;
    logic        dec_done;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        ext_exc;
    logic [31:0] epc;
    logic [1:0]  exc_cause;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .pc_cur       (pc_cur),
        .pc_load      (pc_load),
        .pc_next      (pc_next),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .ir_load      (ir_load),
        .dec_done     (dec_done),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .ext_exc      (ext_exc),
        .epc          (epc),
        .exc_cause    (exc_cause)
    );

    // a: ack cycle (>=TMO means never), d: extra decode wait, k: stall high for cycles 0..k-1,
    // e: ext_exc pulse cycle (-1 none); cycles counted from the first FETCH cycle.
    typedef struct {
        int          a;
        int          d;
        int          k;
        int          e;
        logic        jmp;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic [31:0] pc;
        int          exp_lat;
        logic [31:0] exp_next;
        logic [1:0]  exp_cause;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        imem_ack = 1'b0; dec_done = 1'b0; stall = 1'b0; ext_exc = 1'b0;
        jump = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " pc_load"},  32'(pc_load),   32'd0);
        check({tag, " pc_next"},  pc_next,        RST_V);
        check({tag, " imem_req"}, 32'(imem_req),  32'd0);
        check({tag, " ir_load"},  32'(ir_load),   32'd0);
        check({tag, " epc"},      epc,            32'd0);
        check({tag, " cause"},    32'(exc_cause), 32'd0);
    endtask

    // Release reset, wait for the RESET_VEC load, end at cycle 0 of the first fetch.
    task automatic do_reset(input string tag);
        int found = 0;
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (pc_load) begin
                found = 1;
                break;
            end
        end
        check({tag, " load seen"}, 32'(found), 32'd1);
        check({tag, " pc_next"}, pc_next, RST_V);
        check({tag, " req during load"}, 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Instruction-level reference: phase lengths by arithmetic, then the next-PC priority rules.
    function automatic vec_t model(input vec_t v, input logic [1:0] pcause, input logic [31:0] pepc);
        vec_t r = v;
        int   fc;
        int   u;
        int   l;
        bit   tmo;
        bit   ext;
        tmo = (v.a >= TMO);
        fc  = tmo ? TMO : v.a + 1;
        u   = tmo ? fc : fc + v.d + 1;
        l   = (u > v.k + 1) ? u : v.k + 1;
        ext = (v.e >= fc) && (v.e <= l);
        r.exp_lat   = l;
        r.exp_cause = pcause;
        r.exp_epc   = pepc;
        if (tmo || ext) begin
            r.exp_next = EXC_V; r.exp_cause = tmo ? 2'd3 : 2'd1; r.exp_epc = v.pc;
        end else if (v.jmp) begin
            if (v.jt % 4 != 0) begin
                r.exp_next = EXC_V; r.exp_cause = 2'd2; r.exp_epc = v.pc;
            end else begin
                r.exp_next = v.jt;
            end
        end else if (v.br) begin
            if (v.bt % 4 != 0) begin
                r.exp_next = EXC_V; r.exp_cause = 2'd2; r.exp_epc = v.pc;
            end else begin
                r.exp_next = v.bt;
            end
        end else begin
            r.exp_next = v.pc + 32'd4;
        end
        return r;
    endfunction

    // Entered at cycle 0 (just after the edge that starts FETCH); returns at the next cycle 0.
    task automatic run_instr(input vec_t v, input string tag);
        int          lat = -1;
        int          irc = -1;
        int          fc;
        int          exp_irc;
        logic [31:0] nxt = '0;
        fc      = (v.a >= TMO) ? TMO : v.a + 1;
        exp_irc = (v.a >= TMO) ? -1 : v.a + 1;
        pc_cur = v.pc; jump = v.jmp; jump_target = v.jt;
        branch_taken = v.br; branch_target = v.bt;
        for (int c = 0; c < 40; c++) begin
            imem_ack = (v.a < TMO) && (c == v.a);
            dec_done = (v.a < TMO) && (c == fc + v.d);
            stall    = (c < v.k);
            ext_exc  = (c == v.e);
            @(negedge clk);
            if (c == 0) check({tag, " req"}, 32'(imem_req), 32'd1);
            if (ir_load && irc < 0) irc = c;
            if (pc_load) begin
                lat = c;
                nxt = pc_next;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no pc_load within 40 cycles", tag);
            idle_inputs();
            return;
        end
        check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " pc_next"}, nxt, v.exp_next);
        check({tag, " ir_load cycle"}, 32'(irc), 32'(exp_irc));
        @(posedge clk);
        #1;
        idle_inputs();
        check({tag, " exc_cause"}, 32'(exc_cause), 32'(v.exp_cause));
        check({tag, " epc"}, epc, v.exp_epc);
    endtask

    initial begin
        vec_t        v;
        vec_t        m;
        logic [1:0]  cause_m;
        logic [31:0] epc_m;

        //            a   d  k   e  jmp  jt            br   bt            pc            lat next          cause epc
        tbl[0]  = '{ 0,  0, 0, -1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0007, 2, 32'h0000_000B, 2'd0, 32'h0};
        tbl[1]  = '{ 0,  0, 0, -1, 1'b0, 32'h0,        1'b0, 32'h0,        32'hFFFF_FFFC, 2, 32'h0000_0000, 2'd0, 32'h0};
        tbl[2]  = '{ 0,  0, 0, -1, 1'b0, 32'h0,        1'b1, 32'h8,        32'h0000_0100, 2, 32'h0000_0008, 2'd0, 32'h0};
        tbl[3]  = '{ 0,  0, 0, -1, 1'b1, 32'h40,       1'b1, 32'h8,        32'h0000_0104, 2, 32'h0000_0040, 2'd0, 32'h0};
        tbl[4]  = '{ 0,  0, 0, -1, 1'b1, 32'h42,       1'b0, 32'h0,        32'h0000_0200, 2, 32'h0000_0080, 2'd2, 32'h200};
        tbl[5]  = '{ 0,  0, 5, -1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0300, 6, 32'h0000_0304, 2'd2, 32'h200};
        tbl[6]  = '{99,  0, 0, -1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0400, 8, 32'h0000_0080, 2'd3, 32'h400};
        tbl[7]  = '{ 7,  0, 0, -1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0500, 9, 32'h0000_0504, 2'd3, 32'h400};
        tbl[8]  = '{ 0,  1, 5,  1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0600, 6, 32'h0000_0080, 2'd1, 32'h600};
        tbl[9]  = '{ 0,  0, 0, -1, 1'b0, 32'h0,        1'b1, 32'hA,        32'h0000_0700, 2, 32'h0000_0080, 2'd2, 32'h700};
        tbl[10] = '{99,  0, 9,  9, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0A00,10, 32'h0000_0080, 2'd3, 32'hA00};
        tbl[11] = '{ 2,  0, 0,  1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0800, 4, 32'h0000_0804, 2'd3, 32'hA00};
        tbl[12] = '{ 0,  0, 0, -1, 1'b1, 32'h1000,     1'b1, 32'h3,        32'h0000_0B00, 2, 32'h0000_1000, 2'd3, 32'hA00};
        tbl[13] = '{ 0,  0, 0,  2, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0900, 2, 32'h0000_0080, 2'd1, 32'h900};

        reset = 1'b1;
        pc_cur = '0; jump_target = '0; branch_target = '0;
        idle_inputs();
        #1;
        check_reset_vals("por");
        do_reset("rst0");

        for (int i = 0; i < 14; i++) run_instr(tbl[i], $sformatf("t%0d", i));

        // Async reset in the middle of a fetch, with non-zero epc/cause beforehand.
        pc_cur = 32'h000B_EEF0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("midfetch");
        do_reset("rst1");

        cause_m = 2'd0;
        epc_m   = 32'h0;
        for (int i = 0; i < 40; i++) begin
            v     = tbl[0];
            v.a   = int'($urandom_range(0, 9));
            v.d   = int'($urandom_range(0, 3));
            v.k   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0;
            if ($urandom_range(0, 2) == 0) v.e = int'($urandom_range(0, 14));
            else                           v.e = -1;
            v.jmp = 1'($urandom_range(0, 1));
            v.br  = 1'($urandom_range(0, 1));
            v.jt  = $urandom;
            v.bt  = $urandom;
            if ($urandom_range(0, 3) != 0) v.jt = v.jt & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) != 0) v.bt = v.bt & 32'hFFFF_FFFC;
            v.pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            m = model(v, cause_m, epc_m);
            run_instr(m, $sformatf("r%0d", i));
            cause_m = m.exp_cause;
            epc_m   = m.exp_epc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
